// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type, default sizes and request record for mem_slave
package mem_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DEPTH = 16;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    typedef struct packed {
        logic                      wr_rd;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_WIDTH-1:0]      wdata;
    } req_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x WIDTH storage, async clear, one write port (clk_i, rst_i, we, addr, wdata) with combinational read (rdata)
module mem_array
    import mem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    assign rdata = mem[addr];
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) mem <= '{default: '0};
        else if (we) mem[addr] <= wdata;
endmodule

// File: rtl/mem_slave.sv
// mem_slave: valid/ready memory target with WAIT_STATES latency; ports clk_i, rst_i, valid_i, wr_rd_i, wdata_i, addr_i in; rdata_o, ready_o, err_o out
module mem_slave
    import mem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  wr_rd_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  ready_o,
    output logic                  err_o
);
    typedef struct packed {
        logic                  wr_rd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      wdata;
    } req_w_t;
    state_e           state, nxt;
    logic [3:0]       cnt;
    req_w_t           req, nreq;
    logic             in_range, nin;
    logic [WIDTH-1:0] arr_rdata;
    // nreq is the request that will be held after this edge; the array reads it early so
    // rdata_o can be registered on the same edge that enters RESP
    always_comb begin
        nreq = state == IDLE ? {wr_rd_i, addr_i, wdata_i} : req;
        in_range = 32'(req.addr) < DEPTH;
        nin = 32'(nreq.addr) < DEPTH;
        nxt = state == IDLE ? (valid_i ? (WAIT_STATES > 0 ? WAIT : RESP) : IDLE) :
              state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    end
    mem_array #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_array (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .we(state == RESP && req.wr_rd && in_range),
        .addr(nreq.addr),
        .wdata(req.wdata),
        .rdata(arr_rdata)
    );
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state <= IDLE;
            cnt <= '0;
            req <= '0;
            rdata_o <= '0;
            ready_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            state <= nxt;
            req <= nreq;
            cnt <= state == IDLE ? 4'(WAIT_STATES - 1) : cnt - 4'(state == WAIT);
            ready_o <= nxt == RESP;
            err_o <= nxt == RESP && !nin;
            if (nxt == RESP && !nreq.wr_rd) rdata_o <= nin ? arr_rdata : '0;
        end
endmodule

// File: doc/mem_slave.md
Name: mem_slave

Overview:
- Single-port synchronous memory target that consumes the valid/ready memory bus driven by the verification environment's driver.
- Accepts one read or write per handshake, inserts a programmable number of wait states, then pulses ready_o with read data.
- Flags out-of-range addresses.
- Serves as the DUT behind the memory bus interface in the block-level bench.

Parameters:
WIDTH, 8, data width in bits (matches `WIDTH)
ADDR_WIDTH, 4, address width in bits (matches `ADDR_WIDTH)
DEPTH, 16, number of storage words; DEPTH <= 2**ADDR_WIDTH
WAIT_STATES, 1, extra cycles between request capture and response (0..15)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-high reset
valid_i  input  1  request valid
wr_rd_i  input  1  1 = write, 0 = read
wdata_i  input  WIDTH  write data
addr_i  input  ADDR_WIDTH  word address
rdata_o  output  WIDTH  read data, meaningful while ready_o=1 on a read
ready_o  output  1  one-cycle response/completion pulse
err_o  output  1  out-of-range address flag, qualified by ready_o

Interface: one clock (clk_i); rst_i is asynchronous, active-high.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; ready_o=0; err_o=0; rdata_o=0; wait counter=0; latched request cleared.
  - All DEPTH words cleared to 0.
- FSM states: IDLE, WAIT, RESP. All outputs are registered or decoded from registered state (Moore).
- IDLE:
  - On a rising edge with valid_i=1, latch wr_rd_i, addr_i and wdata_i.
  - Go to WAIT with cnt=WAIT_STATES-1 if WAIT_STATES>0, else go to RESP.
  - Stay in IDLE while valid_i=0.
- WAIT:
  - Decrement cnt each cycle; go to RESP when cnt==0.
  - Inputs are ignored; the latched request is authoritative.
  - If valid_i drops, the transaction still completes.
- RESP (exactly one cycle):
  - ready_o=1; err_o=(latched addr >= DEPTH).
  - Read, in range: rdata_o=mem[addr] for this cycle.
  - Write, in range: mem[addr]<=wdata at the edge ending RESP; rdata_o holds its previous value.
  - Out of range: no array access; rdata_o=0 on reads; writes are discarded.
  - Next state is always IDLE.
- Latency:
  - valid_i sampled at edge N gives ready_o high during cycle N+1+WAIT_STATES.
  - Minimum spacing is 2+WAIT_STATES cycles per transaction (one IDLE cycle between responses).
- Back-to-back: valid_i held high across RESP is re-sampled in IDLE on the next edge. It is not consumed in RESP.
- Read-after-write to the same address in consecutive transactions returns the new data.
- rdata_o holds its last value outside RESP; err_o=0 outside RESP.
- Reset asserted mid-transaction: the transaction is aborted, no write is committed unless its RESP edge already occurred, and the FSM returns to IDLE immediately.
- Unknown state encoding: recover to IDLE.

Decomposition:
- Package mem_pkg holds:
  - state_e enum (IDLE, WAIT, RESP);
  - localparams for default WIDTH/ADDR_WIDTH/DEPTH;
  - req_t struct {wr_rd, addr, wdata} for the latched request.
- One sub-module, mem_array: the storage array with a single read/write port and asynchronous clear. The FSM, wait counter and response logic stay in mem_slave.

Test Plan:
All scenarios use the default parameters (WIDTH=8, ADDR_WIDTH=4, DEPTH=16, WAIT_STATES=1).
- Reset check: assert rst_i mid-run, then read addresses 0..15 -> rdata_o=0x00 for every read, ready_o=0 during reset, err_o=0.
- Write then read: write 0xA5 to addr 3 (valid_i at edge N) -> ready_o=1 in cycle N+2 only; a following read of addr 3 -> rdata_o=0xA5 with ready_o, err_o=0.
- Wait-state sweep: WAIT_STATES=0 and 3 -> ready_o observed at N+1 and N+4 respectively; ready_o width is exactly one cycle in both.
- Back-to-back: valid_i held high with writes 0x11→addr0, 0x22→addr1, then reads of addr0 and addr1 -> responses every 3 cycles; read data 0x11 then 0x22.
- Out of range: instantiate with DEPTH=12; write 0xFF to addr 13, then read addr 13 and addr 11 -> err_o=1 with ready_o for both addr-13 accesses, rdata_o=0x00; addr 11 is unchanged (0x00) with err_o=0.
- Reset mid-op: issue write 0x5A to addr 7, assert rst_i during WAIT -> no ready_o pulse; a subsequent read of addr 7 returns 0x00.
